// File: rtl/controle_ciclo_trabalho.sv
// controle_ciclo_trabalho
// Turns the two front-panel buttons into debounced, auto-repeating duty-cycle
// steps and owns the duty register read by the PWM comparator. Steps land in
// duty_pendente; duty_ativo only follows at a PWM period boundary (fim_periodo),
// so a running period is never truncated.
// Build option: define CONTROLE_CICLO_TRABALHO_AUTOREPETICAO_EN to enable
// hold-to-repeat. Without it every press gives exactly one step.
module controle_ciclo_trabalho #(
  parameter int LARGURA           = 8,
  parameter int PASSO             = 16,
  parameter int DUTY_MAX          = 255,
  parameter int DUTY_INICIAL      = 128,
  parameter int DEBOUNCE_CICLOS   = 500000,
  parameter int ATRASO_REPETICAO  = 25000000,
  parameter int PERIODO_REPETICAO = 5000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_mais,
  input  logic               btn_menos,
  input  logic               fim_periodo,
  output logic [LARGURA-1:0] duty_ativo,
  output logic [LARGURA-1:0] duty_pendente,
  output logic               atualizacao_pendente,
  output logic               no_limite
);

  typedef enum logic [1:0] {
    ESPERANDO = 2'd0,
    FILTRANDO = 2'd1,
    ATRASO    = 2'd2,
    REPETINDO = 2'd3
  } estado_t;

  // Step arithmetic runs one bit wider so the upward sum cannot wrap.
  localparam int LW1 = LARGURA + 1;
  localparam logic [LW1-1:0]     PASSO_X = LW1'(PASSO);
  localparam logic [LW1-1:0]     MAX_X   = LW1'(DUTY_MAX);
  localparam logic [LARGURA-1:0] MAX_L   = LARGURA'(DUTY_MAX);
  localparam logic [LARGURA-1:0] INI_L   = LARGURA'(DUTY_INICIAL);

`ifdef CONTROLE_CICLO_TRABALHO_AUTOREPETICAO_EN
  localparam int MAX_AP  = (ATRASO_REPETICAO > PERIODO_REPETICAO) ? ATRASO_REPETICAO : PERIODO_REPETICAO;
  localparam int CNT_MAX = (DEBOUNCE_CICLOS > MAX_AP) ? DEBOUNCE_CICLOS : MAX_AP;
`else
  // Repeat timings are ignored; they appear multiplied by zero only so the
  // parameter list stays identical in both builds.
  localparam int CNT_MAX = DEBOUNCE_CICLOS + 0 * ATRASO_REPETICAO + 0 * PERIODO_REPETICAO;
`endif
  localparam int CW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] UM_C    = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [CW-1:0] LIM_DEB = CW'(DEBOUNCE_CICLOS - 1);
`ifdef CONTROLE_CICLO_TRABALHO_AUTOREPETICAO_EN
  localparam logic [CW-1:0] LIM_ATR = CW'(ATRASO_REPETICAO - 1);
  localparam logic [CW-1:0] LIM_PER = CW'(PERIODO_REPETICAO - 1);
`endif

  logic [1:0]         sinc_mais_r;
  logic [1:0]         sinc_menos_r;
  logic               s_mais;
  logic               s_menos;
  estado_t            estado_r;
  logic [CW-1:0]      cnt_r;
  logic               dir_r;
  logic               padrao_ok_s;
  logic               passo_s;
  logic [LW1-1:0]     soma_s;
  logic [LW1-1:0]     dif_s;
  logic [LARGURA-1:0] proximo_s;
  logic               muda_s;

  assign s_mais    = sinc_mais_r[1];
  assign s_menos   = sinc_menos_r[1];
  assign no_limite = (duty_pendente == {LARGURA{1'b0}}) || (duty_pendente == MAX_L);

  // Two-flop synchronizers for the asynchronous button pins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc_mais_r  <= 2'b00;
      sinc_menos_r <= 2'b00;
    end else begin
      sinc_mais_r  <= {sinc_mais_r[0], btn_mais};
      sinc_menos_r <= {sinc_menos_r[0], btn_menos};
    end
  end

  // Press still valid, step-fire decision and saturated next duty value.
  always_comb begin
    padrao_ok_s = (s_mais ^ s_menos) && (s_mais == dir_r);
    passo_s     = 1'b0;
    case (estado_r)
      FILTRANDO: passo_s = padrao_ok_s && (cnt_r == LIM_DEB);
`ifdef CONTROLE_CICLO_TRABALHO_AUTOREPETICAO_EN
      ATRASO:    passo_s = padrao_ok_s && (cnt_r == LIM_ATR);
      REPETINDO: passo_s = padrao_ok_s && (cnt_r == LIM_PER);
`endif
      default:   passo_s = 1'b0;
    endcase
    soma_s = {1'b0, duty_pendente} + PASSO_X;
    dif_s  = {1'b0, duty_pendente} - PASSO_X;
    if (dir_r) begin
      if (soma_s > MAX_X) begin
        proximo_s = MAX_L;
      end else begin
        proximo_s = soma_s[LARGURA-1:0];
      end
    end else begin
      if ({1'b0, duty_pendente} < PASSO_X) begin
        proximo_s = {LARGURA{1'b0}};
      end else begin
        proximo_s = dif_s[LARGURA-1:0];
      end
    end
    muda_s = (proximo_s != duty_pendente);
  end

  // Press sequencer: debounce, first-repeat delay, repeat cadence.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_r <= ESPERANDO;
      cnt_r    <= ZERO_C;
      dir_r    <= 1'b0;
    end else begin
      case (estado_r)
        ESPERANDO: begin
          cnt_r <= ZERO_C;
          if (s_mais ^ s_menos) begin
            dir_r    <= s_mais;
            estado_r <= FILTRANDO;
          end else begin
            estado_r <= ESPERANDO;
          end
        end
        FILTRANDO: begin
          if (!padrao_ok_s) begin
            estado_r <= ESPERANDO;
            cnt_r    <= ZERO_C;
          end else if (passo_s) begin
            estado_r <= ATRASO;
            cnt_r    <= ZERO_C;
          end else begin
            cnt_r <= cnt_r + UM_C;
          end
        end
        ATRASO: begin
          if (!padrao_ok_s) begin
            estado_r <= ESPERANDO;
            cnt_r    <= ZERO_C;
`ifdef CONTROLE_CICLO_TRABALHO_AUTOREPETICAO_EN
          end else if (passo_s) begin
            estado_r <= REPETINDO;
            cnt_r    <= ZERO_C;
          end else begin
            cnt_r <= cnt_r + UM_C;
          end
`else
          end else begin
            cnt_r <= cnt_r;
          end
`endif
        end
`ifdef CONTROLE_CICLO_TRABALHO_AUTOREPETICAO_EN
        REPETINDO: begin
          if (!padrao_ok_s) begin
            estado_r <= ESPERANDO;
            cnt_r    <= ZERO_C;
          end else if (passo_s) begin
            cnt_r <= ZERO_C;
          end else begin
            cnt_r <= cnt_r + UM_C;
          end
        end
`endif
        default: begin
          estado_r <= ESPERANDO;
          cnt_r    <= ZERO_C;
        end
      endcase
    end
  end

  // Pending/active duty registers and the update-pending flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      duty_ativo           <= INI_L;
      duty_pendente        <= INI_L;
      atualizacao_pendente <= 1'b0;
    end else begin
      if (fim_periodo) begin
        duty_ativo <= duty_pendente;
      end else begin
        duty_ativo <= duty_ativo;
      end
      if (passo_s) begin
        duty_pendente <= proximo_s;
      end else begin
        duty_pendente <= duty_pendente;
      end
      if (passo_s && muda_s) begin
        atualizacao_pendente <= 1'b1;
      end else if (fim_periodo) begin
        atualizacao_pendente <= 1'b0;
      end else begin
        atualizacao_pendente <= atualizacao_pendente;
      end
    end
  end

endmodule

// File: tb/tb_controle_ciclo_trabalho.sv
// Directed bench for controle_ciclo_trabalho (LARGURA=8, PASSO=16,
// DUTY_MAX=255, DUTY_INICIAL=128, DEBOUNCE=4, ATRASO=8, PERIODO=3).
// Expectations follow CONTROLE_CICLO_TRABALHO_AUTOREPETICAO_EN as seen here.
module tb_controle_ciclo_trabalho;

`ifdef CONTROLE_CICLO_TRABALHO_AUTOREPETICAO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_mais;
  logic       btn_menos;
  logic       fim_periodo;
  logic [7:0] duty_ativo;
  logic [7:0] duty_pendente;
  logic       atualizacao_pendente;
  logic       no_limite;
  int         n_vetores = 0;
  int         n_erros   = 0;

  controle_ciclo_trabalho #(
    .LARGURA(8), .PASSO(16), .DUTY_MAX(255), .DUTY_INICIAL(128),
    .DEBOUNCE_CICLOS(4), .ATRASO_REPETICAO(8), .PERIODO_REPETICAO(3)
  ) dut (
    .clock(clock), .reset(reset), .btn_mais(btn_mais), .btn_menos(btn_menos),
    .fim_periodo(fim_periodo), .duty_ativo(duty_ativo), .duty_pendente(duty_pendente),
    .atualizacao_pendente(atualizacao_pendente), .no_limite(no_limite)
  );

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_vetores++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, esp);
    end
  endtask

  // Advance n rising edges, returning at the following falling edge.
  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulso_fim();
    fim_periodo = 1'b1;
    ciclos(1);
    fim_periodo = 1'b0;
  endtask

  task automatic aplica_reset();
    reset = 1'b1;
    ciclos(2);
    reset = 1'b0;
    ciclos(1);
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    reset = 1'b1; btn_mais = 1'b0; btn_menos = 1'b0; fim_periodo = 1'b0;
    ciclos(2);
    confere("rst_ativo", duty_ativo, 128);
    confere("rst_pend", duty_pendente, 128);
    confere("rst_flag", atualizacao_pendente, 0);
    confere("rst_lim", no_limite, 0);
    reset = 1'b0;
    ciclos(2);

    // 1: single press, commit at period boundary
    btn_mais = 1'b1;
    ciclos(6);  confere("t1_pre", duty_pendente, 128);
    ciclos(1);  confere("t1_pend", duty_pendente, 144);
    confere("t1_flag", atualizacao_pendente, 1);
    confere("t1_ativo", duty_ativo, 128);
    btn_mais = 1'b0;
    ciclos(4);  confere("t1_ativo_hold", duty_ativo, 128);
    pulso_fim();
    confere("t1_commit", duty_ativo, 144);
    confere("t1_flag_clr", atualizacao_pendente, 0);

    // 2: 3-cycle glitch gives no step
    btn_menos = 1'b1;
    ciclos(3);
    btn_menos = 1'b0;
    ciclos(6);
    confere("t2_pend", duty_pendente, 144);
    confere("t2_flag", atualizacao_pendente, 0);

    // 3: long hold up to saturation
    btn_mais = 1'b1;
    ciclos(7);  confere("t3_k6", duty_pendente, 160);
    ciclos(7);  confere("t3_k13", duty_pendente, 160);
    ciclos(1);  confere("t3_k14", duty_pendente, AUTO ? 176 : 160);
    ciclos(3);  confere("t3_k17", duty_pendente, AUTO ? 192 : 160);
    ciclos(12); confere("t3_k29", duty_pendente, AUTO ? 255 : 160);
    confere("t3_lim", no_limite, AUTO ? 1 : 0);
    pulso_fim();
    confere("t3_ativo", duty_ativo, AUTO ? 255 : 160);
    confere("t3_flag_clr", atualizacao_pendente, 0);
    ciclos(3);
    confere("t3_sat_pend", duty_pendente, AUTO ? 255 : 160);
    confere("t3_sat_flag", atualizacao_pendente, 0);
    ciclos(6);
    btn_mais = 1'b0;
    ciclos(4);

    // 4: hold down, both buttons mid-repeat, then floor at zero
    aplica_reset();
    btn_menos = 1'b1;
    ciclos(7);  confere("t4_k6", duty_pendente, 112);
    ciclos(23); confere("t4_k29", duty_pendente, AUTO ? 16 : 112);
    confere("t4_lim0", no_limite, 0);
    btn_mais = 1'b1;
    ciclos(3);  confere("t4_both", duty_pendente, AUTO ? 16 : 112);
    ciclos(7);  confere("t4_both_hold", duty_pendente, AUTO ? 16 : 112);
    btn_mais = 1'b0;
    ciclos(6);  confere("t4_refilt", duty_pendente, AUTO ? 16 : 112);
    ciclos(1);  confere("t4_floor", duty_pendente, AUTO ? 0 : 96);
    confere("t4_lim1", no_limite, AUTO ? 1 : 0);
    ciclos(10); confere("t4_floor_hold", duty_pendente, AUTO ? 0 : 96);
    btn_menos = 1'b0;
    ciclos(4);

    // 5: step and fim_periodo on the same edge
    aplica_reset();
    btn_mais = 1'b1;
    ciclos(7);  confere("t5_k6", duty_pendente, 144);
    ciclos(3);
    pulso_fim();
    confere("t5_c1_ativo", duty_ativo, 144);
    confere("t5_c1_flag", atualizacao_pendente, 0);
    ciclos(3);
    pulso_fim();
    confere("t5_ativo", duty_ativo, 144);
    confere("t5_pend", duty_pendente, AUTO ? 160 : 144);
    confere("t5_flag", atualizacao_pendente, AUTO ? 1 : 0);
    btn_mais = 1'b0;
    ciclos(4);

    // 6: asynchronous reset while repeating, then refilter
    aplica_reset();
    btn_mais = 1'b1;
    ciclos(19); confere("t6_k18", duty_pendente, AUTO ? 176 : 144);
    pulso_fim();
    confere("t6_ativo", duty_ativo, AUTO ? 176 : 144);
    ciclos(1);
    #2 reset = 1'b1;
    #1;
    confere("t6_async_pend", duty_pendente, 128);
    confere("t6_async_ativo", duty_ativo, 128);
    confere("t6_async_flag", atualizacao_pendente, 0);
    confere("t6_async_lim", no_limite, 0);
    ciclos(1);
    reset = 1'b0;
    ciclos(6);  confere("t6_refilt", duty_pendente, 128);
    ciclos(1);  confere("t6_step", duty_pendente, 144);
    btn_mais = 1'b0;
    ciclos(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
    $finish;
  end

endmodule
